// File: rtl/expr_hammer_pkg.sv
// Shared definitions for the vloghammer stimulus/response drivers:
// operand widths, result width, driver states, result fold and MISR defaults.
package expr_hammer_pkg;

    localparam int U0_W  = 4;
    localparam int U1_W  = 5;
    localparam int U2_W  = 6;
    localparam int S3_W  = 4;
    localparam int S4_W  = 5;
    localparam int S5_W  = 6;
    localparam int OPS_W = 60;
    localparam int Y_W   = 90;

    localparam logic [31:0] SIG_POLY_DEF = 32'h04C1_1DB7;
    localparam logic [31:0] SIG_INIT_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Compact the 90-bit packed result into one 32-bit MISR input word.
    function automatic logic [31:0] fold(input logic [Y_W-1:0] y);
        return y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
    endfunction

endpackage

// File: rtl/misr32.sv
// 32-bit Galois MISR: clr reloads SIG_INIT, en absorbs one din word per cycle.
module misr32
    import expr_hammer_pkg::*;
#(
    parameter logic [31:0] SIG_INIT = SIG_INIT_DEF,
    parameter logic [31:0] SIG_POLY = SIG_POLY_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] sig
);

    logic [31:0] sig_q;
    logic [31:0] sig_d;

    // NOTE: default assigned first so every path drives sig_d and no latch is inferred.
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = SIG_INIT;
        end else if (en) begin
            sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? SIG_POLY : 32'h0) ^ din;
        end
    end

    // NOTE: non-blocking assignment for state so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SIG_INIT;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/expr_vector_driver.sv
// Closed-loop driver for expression_NNNNN blocks: LFSR operand source, MISR
// response compaction and a run-length FSM that compares against exp_sig.
module expr_vector_driver
    import expr_hammer_pkg::*;
#(
    parameter logic [59:0] LFSR_SEED = 60'h1,
    parameter logic [31:0] SIG_INIT  = SIG_INIT_DEF,
    parameter logic [31:0] SIG_POLY  = SIG_POLY_DEF,
    parameter int          CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        nvec,
    input  logic [31:0]             exp_sig,
    input  logic [Y_W-1:0]          y,
    output logic [U0_W-1:0]         a0,
    output logic [U1_W-1:0]         a1,
    output logic [U2_W-1:0]         a2,
    output logic signed [S3_W-1:0]  a3,
    output logic signed [S4_W-1:0]  a4,
    output logic signed [S5_W-1:0]  a5,
    output logic [U0_W-1:0]         b0,
    output logic [U1_W-1:0]         b1,
    output logic [U2_W-1:0]         b2,
    output logic signed [S3_W-1:0]  b3,
    output logic signed [S4_W-1:0]  b4,
    output logic signed [S5_W-1:0]  b5,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [31:0]             sig,
    output logic [CNT_W-1:0]        vec_cnt
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [59:0] SEED = (LFSR_SEED == 60'h0) ? 60'h1 : LFSR_SEED;

    state_e             state_q, state_d;
    logic [OPS_W-1:0]   lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   nvec_q, nvec_d;
    logic [31:0]        exp_q, exp_d;
    logic               done_q, done_d;
    logic               misr_clr;
    logic               misr_en;
    logic [CNT_W-1:0]   cnt_inc;
    logic [31:0]        sig_w;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        nvec_d   = nvec_q;
        exp_d    = exp_q;
        done_d   = 1'b0;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    nvec_d   = nvec;
                    exp_d    = exp_sig;
                    lfsr_d   = SEED;
                    cnt_d    = '0;
                    misr_clr = 1'b1;
                    state_d  = (nvec == '0) ? DONE : RUN;
                    done_d   = (nvec == '0);
                end
            end
            RUN: begin
                // y reflects the operands presented this cycle; absorb it, then advance.
                misr_en = 1'b1;
                lfsr_d  = {lfsr_q[58:0], lfsr_q[59] ^ lfsr_q[58]};
                cnt_d   = cnt_inc;
                if (cnt_inc == nvec_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            nvec_q  <= '0;
            exp_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            nvec_q  <= nvec_d;
            exp_q   <= exp_d;
            done_q  <= done_d;
        end
    end

    misr32 #(
        .SIG_INIT (SIG_INIT),
        .SIG_POLY (SIG_POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (misr_en),
        .din   (fold(y)),
        .sig   (sig_w)
    );

    assign {a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5} = lfsr_q;

    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign pass    = (state_q == DONE) && (sig_w == exp_q);
    assign sig     = sig_w;
    assign vec_cnt = cnt_q;

endmodule
